// File: rtl/psum_pkg.sv
// Shared types and constants for the psum_adder partial-sum producer.
package psum_pkg;

  localparam int CNT_W          = 4;
  localparam int PSUM_WIDTH_DEF = 8;
  localparam int PSUM_N_ACC_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV_SUM,
    S_RECV_OP,
    S_SEND_NEXT,
    S_SEND_OUT
  } psum_state_t;

endpackage

// File: rtl/psum_add_unit.sv
// Unsigned WIDTH-bit adder: wraps modulo 2^WIDTH, or saturates and flags
// overflow when PSUM_SAT_EN is defined.
module psum_add_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef PSUM_SAT_EN
  output logic             ovf_o,
`endif
  output logic [WIDTH-1:0] sum_o
);

`ifdef PSUM_SAT_EN
  logic [WIDTH:0] full;

  assign full  = {1'b0, a_i} + {1'b0, b_i};
  assign ovf_o = full[WIDTH];
  assign sum_o = full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
  assign sum_o = a_i + b_i;
`endif

endmodule

// File: rtl/psum_adder.sv
// Partial-sum producer: adds one operand per accumulation round, returns the
// result to the accumulator, and forwards the group total after N_ACC rounds.
// Optional saturating arithmetic under the PSUM_SAT_EN macro.
module psum_adder
  import psum_pkg::*;
#(
  parameter int WIDTH = PSUM_WIDTH_DEF,
  parameter int N_ACC = PSUM_N_ACC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sum_valid,
  output logic             sum_ready,
  input  logic [WIDTH-1:0] sum_data,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_data,
  output logic             next_valid,
  input  logic             next_ready,
  output logic [WIDTH-1:0] next_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             grp_err
);

  localparam logic [CNT_W-1:0] N_ACC_C = CNT_W'(N_ACC);

  psum_state_t      state_q;
  logic [CNT_W-1:0] acc_cnt_q;
  logic [CNT_W-1:0] acc_cnt_d;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] next_data_q;
  logic [WIDTH-1:0] out_data_q;
  logic             grp_err_q;
  logic [WIDTH-1:0] add_sum;

  // Handshake strobes: every channel uses valid/ready, a transfer happens on
  // the rising clk edge where both are high; each state owns one channel only.
  assign sum_ready  = (state_q == S_RECV_SUM);
  assign op_ready   = (state_q == S_RECV_OP);
  assign next_valid = (state_q == S_SEND_NEXT);
  assign out_valid  = (state_q == S_SEND_OUT);
  assign next_data  = next_data_q;
  assign out_data   = out_data_q;

  assign acc_cnt_d = (acc_cnt_q == N_ACC_C) ? '0 : acc_cnt_q + CNT_W'(1);

`ifdef PSUM_SAT_EN
  logic add_ovf;
  logic sat_q;

  psum_add_unit #(.WIDTH(WIDTH)) u_add (
    .a_i   (psum_q),
    .b_i   (op_data),
    .ovf_o (add_ovf),
    .sum_o (add_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else if (state_q == S_RECV_OP && op_valid && add_ovf) begin
      sat_q <= 1'b1;
    end
  end

  assign grp_err = grp_err_q | sat_q;
`else
  psum_add_unit #(.WIDTH(WIDTH)) u_add (
    .a_i   (psum_q),
    .b_i   (op_data),
    .sum_o (add_sum)
  );

  assign grp_err = grp_err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_cnt_q   <= '0;
      psum_q      <= '0;
      next_data_q <= '0;
      out_data_q  <= '0;
      grp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_RECV_SUM;
        S_RECV_SUM: begin
          if (sum_valid) begin
            psum_q <= sum_data;
            if (acc_cnt_q == N_ACC_C) begin
              out_data_q <= sum_data;
              state_q    <= S_SEND_OUT;
            end else begin
              state_q <= S_RECV_OP;
            end
            // A group must open with the accumulator's zero reset sum.
            if (acc_cnt_q == '0 && sum_data != '0) grp_err_q <= 1'b1;
          end
        end
        S_RECV_OP: begin
          if (op_valid) begin
            next_data_q <= add_sum;
            state_q     <= S_SEND_NEXT;
          end
        end
        S_SEND_NEXT: begin
          if (next_ready) begin
            acc_cnt_q <= acc_cnt_d;
            state_q   <= S_RECV_SUM;
          end
        end
        S_SEND_OUT: begin
          if (out_ready) begin
            acc_cnt_q <= '0;
            state_q   <= S_RECV_SUM;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_adder.sv
// Directed scoreboard bench for psum_adder (WIDTH=8, N_ACC=2); expectations
// follow PSUM_SAT_EN when the macro is defined for the build.
module tb_psum_adder;

  localparam int W   = 8;
  localparam int TMO = 50;

`ifdef PSUM_SAT_EN
  localparam logic [W-1:0] EXP_WRAP = 8'd255;
  localparam logic         EXP_SERR = 1'b1;
`else
  localparam logic [W-1:0] EXP_WRAP = 8'd4;
  localparam logic         EXP_SERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sum_valid = 1'b0;
  logic         sum_ready;
  logic [W-1:0] sum_data = '0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [W-1:0] op_data = '0;
  logic         next_valid;
  logic         next_ready = 1'b0;
  logic [W-1:0] next_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         grp_err;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_next_q[$];
  logic [W-1:0] exp_out_q[$];

  psum_adder #(.WIDTH(W), .N_ACC(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum_data   (sum_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_data    (op_data),
    .next_valid (next_valid),
    .next_ready (next_ready),
    .next_data  (next_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .grp_err    (grp_err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s_timeout: got no handshake expected one within %0d cycles", name, TMO);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset && next_valid && next_ready) begin
      if (exp_next_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL next_unexpected: got %0d expected no transfer", next_data);
      end else begin
        e = exp_next_q.pop_front();
        chk("next_data", 32'(next_data), 32'(e));
      end
    end
    if (!reset && out_valid && out_ready) begin
      if (exp_out_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL out_unexpected: got %0d expected no transfer", out_data);
      end else begin
        e = exp_out_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
      end
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic send_sum(input logic [W-1:0] d);
    int cyc = 0;
    sum_valid = 1'b1;
    sum_data  = d;
    while (!sum_ready && cyc < TMO) begin @(posedge clk); #1; cyc++; end
    if (!sum_ready) timeout("sum");
    @(posedge clk); #1;
    sum_valid = 1'b0;
  endtask

  task automatic send_op(input logic [W-1:0] d);
    int cyc = 0;
    op_valid = 1'b1;
    op_data  = d;
    while (!op_ready && cyc < TMO) begin @(posedge clk); #1; cyc++; end
    if (!op_ready) timeout("op");
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic recv_next(input logic [W-1:0] e, input int nst, output logic [W-1:0] d);
    int cyc = 0;
    exp_next_q.push_back(e);
    next_ready = 1'b0;
    for (int i = 0; i < nst; i++) begin
      @(negedge clk);
      chk("bp_next_valid", 32'(next_valid), 32'd1);
      chk("bp_next_stable", 32'(next_data), 32'(e));
      chk("bp_op_ready", 32'(op_ready), 32'd0);
      @(posedge clk); #1;
    end
    next_ready = 1'b1;
    while (!next_valid && cyc < TMO) begin @(posedge clk); #1; cyc++; end
    if (!next_valid) timeout("next");
    d = next_data;
    @(posedge clk); #1;
    next_ready = 1'b0;
  endtask

  task automatic recv_out(input logic [W-1:0] e, input int nst);
    int cyc = 0;
    exp_out_q.push_back(e);
    out_ready = 1'b0;
    for (int i = 0; i < nst; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_stable", 32'(out_data), 32'(e));
      chk("stall_sum_ready", 32'(sum_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    while (!out_valid && cyc < TMO) begin @(posedge clk); #1; cyc++; end
    if (!out_valid) timeout("out");
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // One full N_ACC=2 group; the returned next value is fed back as the sum.
  task automatic run_group(input logic [W-1:0] s0, input logic [W-1:0] op0,
                           input logic [W-1:0] op1, input logic [W-1:0] e0,
                           input logic [W-1:0] e1, input int nst, input int ost);
    logic [W-1:0] d;
    send_sum(s0);
    send_op(op0);
    chk("op_to_next_lat", 32'(next_valid), 32'd1);
    recv_next(e0, nst, d);
    send_sum(d);
    send_op(op1);
    recv_next(e1, 0, d);
    send_sum(d);
    chk("sum_to_out_lat", 32'(out_valid), 32'd1);
    recv_out(e1, ost);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sum_ready", 32'(sum_ready), 32'd0);
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk("rst_next_valid", 32'(next_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_next_data", 32'(next_data), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_grp_err", 32'(grp_err), 32'd0);
    #1 reset = 1'b0;
    #1 chk("idle_sum_ready", 32'(sum_ready), 32'd0);
    @(posedge clk); #1;
    chk("recv_sum_ready", 32'(sum_ready), 32'd1);

    // basic group: 0+5=5, 5+7=12
    run_group(8'd0, 8'd5, 8'd7, 8'd5, 8'd12, 0, 0);
    chk("basic_grp_err", 32'(grp_err), 32'd0);

    // back-pressure on next: 0+20=20 held 4 cycles, 20+30=50
    run_group(8'd0, 8'd20, 8'd30, 8'd20, 8'd50, 4, 0);

    // two consecutive groups with out stalled 3 cycles
    run_group(8'd0, 8'd5, 8'd7, 8'd5, 8'd12, 0, 3);
    run_group(8'd0, 8'd9, 8'd11, 8'd9, 8'd20, 0, 0);
    chk("consec_grp_err", 32'(grp_err), 32'd0);

    // wrap / saturate: 0+250=250, 250+10 -> 4 or 255
    run_group(8'd0, 8'd250, 8'd10, 8'd250, EXP_WRAP, 0, 0);
    chk("wrap_grp_err", 32'(grp_err), 32'(EXP_SERR));

    // reset while next is offered
    send_sum(8'd0);
    send_op(8'd5);
    chk("pre_rst_next_valid", 32'(next_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_next_valid", 32'(next_valid), 32'd0);
    chk("async_sum_ready", 32'(sum_ready), 32'd0);
    chk("async_grp_err", 32'(grp_err), 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    #1 chk("post_rst_idle", 32'(sum_ready), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_sum_ready", 32'(sum_ready), 32'd1);

    // bad opening sum 3 right after reset: 3+5=8, 8+7=15, counter restarted
    chk("bad_open_pre_err", 32'(grp_err), 32'd0);
    send_sum(8'd3);
    chk("bad_open_err_rise", 32'(grp_err), 32'd1);
    send_op(8'd5);
    begin
      logic [W-1:0] d;
      recv_next(8'd8, 0, d);
      send_sum(d);
      send_op(8'd7);
      recv_next(8'd15, 0, d);
      send_sum(d);
    end
    chk("bad_open_out_lat", 32'(out_valid), 32'd1);
    recv_out(8'd15, 0);
    chk("bad_open_err_sticky", 32'(grp_err), 32'd1);

    repeat (2) @(posedge clk);
    chk("next_q_drained", 32'(exp_next_q.size()), 32'd0);
    chk("out_q_drained", 32'(exp_out_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psum_adder.md
Name: psum_adder

Overview:
Clocked partial-sum producer for the two-step accumulation loop. It sits on the far side of the accumulator's sum/next channel pair.
- Receives the current partial sum from the accumulator and adds one incoming operand (e.g. a product) to it.
- Returns the result to the accumulator as its next value.
- After N_ACC accumulations, forwards the final sum downstream instead of adding to it.
- All channels are valid/ready; a transfer occurs on the rising clk edge where both are high.

Parameters:
- WIDTH, 8, data width of sum, operand, next and result.
- N_ACC, 2, accumulations per group; legal range 1..15.

Ports:
- clk  input  1  single system clock.
- reset  input  1  asynchronous, active-high reset.
- sum_valid  input  1  accumulator presents a partial sum.
- sum_ready  output  1  block accepts a partial sum.
- sum_data  input  WIDTH  partial sum from the accumulator.
- op_valid  input  1  operand available.
- op_ready  output  1  block accepts an operand.
- op_data  input  WIDTH  operand to add.
- next_valid  output  1  next sum offered to the accumulator.
- next_ready  input  1  accumulator accepts the next sum.
- next_data  output  WIDTH  partial sum plus operand.
- out_valid  output  1  final group result offered.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  final accumulated value.
- grp_err  output  1  sticky: group-opening sum was nonzero.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: state S_IDLE, acc_cnt 0, all registered outputs 0 (sum_ready, op_ready, next_valid, out_valid, next_data, out_data, grp_err).
- All handshake outputs are decoded from registered state and are never combinational from inputs.
- State S_IDLE: entered only by reset. Goes to S_RECV_SUM on the first clk edge after reset deasserts.
- State S_RECV_SUM: sum_ready=1.
  - On a sum handshake, latch sum_data into psum_q.
  - If acc_cnt==N_ACC, go to S_SEND_OUT and load out_data=psum_q.
  - Otherwise go to S_RECV_OP.
  - If acc_cnt==0 and sum_data!=0, set grp_err (this is the accumulator's reset sum).
- State S_RECV_OP: op_ready=1. On an op handshake, next_data = psum_q + op_data (WIDTH-bit result), then go to S_SEND_NEXT.
- State S_SEND_NEXT: next_valid=1 and next_data held stable. On a next handshake, acc_cnt++ and go to S_RECV_SUM.
- State S_SEND_OUT: out_valid=1 and out_data held stable. On an out handshake, acc_cnt=0 and go to S_RECV_SUM.
- Channel rules:
  - At most one channel is active per state, so simultaneous valids on other channels are ignored (ready=0).
  - Once valid is raised it stays high with stable data until the transfer completes.
- Latency: operand accepted to next_valid is 1 cycle; final sum accepted to out_valid is 1 cycle. Minimum loop is 3 cycles per accumulation.
- Arithmetic: unsigned, wraps modulo 2^WIDTH by default, carry discarded.
- Counter: acc_cnt is 4 bits and wraps 0..N_ACC only.
- grp_err: cleared only by reset.
- Reset mid-transfer: any pending valid/ready drops asynchronously and the partial group is discarded. The upstream accumulator must be reset together with this block.

Optional Feature:
- Macro PSUM_SAT_EN.
- Defined: addition saturates to 2^WIDTH-1 on unsigned overflow, and the overflow sets a sticky saturation bit that is ORed into grp_err.
- Undefined: wrap-around addition; grp_err reflects only the nonzero-opening-sum check.

Decomposition:
- Package psum_pkg holds:
  - the typedef enum logic[2:0] psum_state_t {S_IDLE, S_RECV_SUM, S_RECV_OP, S_SEND_NEXT, S_SEND_OUT};
  - the localparam CNT_W=4;
  - the default WIDTH/N_ACC constants.
- Sub-module psum_add_unit (combinational, WIDTH-parameterised) implements the wrap or saturating add under PSUM_SAT_EN. The FSM, counter and handshake registers live in psum_adder.

Test Plan:
- Basic group (WIDTH=8, N_ACC=2): sums 0, then returned next values; operands 5, 7 -> next_data 5 then 12; out_data=12; grp_err=0.
- Back-pressure: next_ready held low 4 cycles -> next_valid stays 1 with next_data stable, and op_ready stays 0 throughout.
- Wrap: sum 250 + op 10 -> next_data 4 (macro off). With PSUM_SAT_EN -> 255 and grp_err=1.
- Bad opening: first sum 3 after reset -> grp_err rises the cycle after the handshake; accumulation still completes.
- Reset mid-operation: assert reset while in S_SEND_NEXT -> next_valid=0 immediately; after release sum_ready=1 one cycle later, acc_cnt restarts at 0.
- Two consecutive groups, out_ready stalled 3 cycles -> second group starts only after the out handshake; results 12 and 20 for operands {5,7} and {9,11}.
